// File: rtl/pio_mem_rd_arb_pkg.sv
// Shared constants and helpers for the PIO memory read arbiter.
// Tag width and round-robin pointer advance are reused by other PIO arbiters.
package pio_mem_rd_arb_pkg;

    localparam int MEM_LAT_DEF = 3;

    function automatic int tag_w(input int nreq);
        return (nreq > 1) ? $clog2(nreq) : 1;
    endfunction

    function automatic int rr_next(input int idx, input int nreq);
        return (idx >= nreq - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/pio_mem_rd_arb_rr_arb.sv
// Combinational round-robin arbiter: first set request at or after the
// pointer, wrapping, as a one-hot grant plus the winner index.
module pio_mem_rd_arb_rr_arb
    import pio_mem_rd_arb_pkg::*;
#(
    parameter int NREQ = 4,
    localparam int TW = tag_w(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [TW-1:0]   ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [TW-1:0]   idx_o
);

    logic found;
    int   j;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 0; k < NREQ; k++) begin
            j = (int'(ptr_i) + k) % NREQ;
            if (!found && req_i[j]) begin
                found    = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = TW'(j);
            end
        end
    end

endmodule

// File: rtl/pio_mem_rd_arb.sv
// Round-robin sharing of a PIO memory app read port with in-order tag return
// and a burst limiter that leaves idle slots for PIO register reads.
module pio_mem_rd_arb
    import pio_mem_rd_arb_pkg::*;
#(
    parameter int NREQ        = 4,
    parameter int WIDTH       = 20,
    parameter int DEPTH_NBITS = 10,
    parameter int MEM_LAT     = MEM_LAT_DEF,
    parameter int MAX_BURST   = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NREQ-1:0]             req,
    input  logic [NREQ*DEPTH_NBITS-1:0] req_addr,
    output logic [NREQ-1:0]             gnt,
    output logic [NREQ-1:0]             rsp_vld,
    output logic [WIDTH-1:0]            rsp_data,
    output logic                        app_mem_rd,
    output logic [DEPTH_NBITS-1:0]      app_mem_raddr,
    input  logic                        app_mem_ack,
    input  logic [WIDTH-1:0]            app_mem_rdata,
    output logic                        err_orphan_ack
);

    localparam int TW = tag_w(NREQ);
    localparam int FD = MEM_LAT + 2;
    localparam int PW = (FD > 1) ? $clog2(FD) : 1;
    localparam int CW = $clog2(FD + 1);
    localparam int BW = $clog2(MAX_BURST + 1);

    logic [TW-1:0]          ptr_q, ptr_d;
    logic [BW-1:0]          bcnt_q, bcnt_d;
    logic                   rd_q, rd_d;
    logic [DEPTH_NBITS-1:0] raddr_q, raddr_d;
    logic [NREQ-1:0]        vld_q, vld_d;
    logic [WIDTH-1:0]       data_q, data_d;
    logic                   err_q, err_d;
    logic [TW-1:0]          fifo_q [FD];
    logic [PW-1:0]          wp_q, wp_d, rp_q, rp_d;
    logic [CW-1:0]          cnt_q, cnt_d;

    logic [NREQ-1:0] arb_gnt;
    logic [TW-1:0]   win;
    logic            fire, pop, orphan;

    pio_mem_rd_arb_rr_arb #(.NREQ(NREQ)) u_rr (
        .req_i (req),
        .ptr_i (ptr_q),
        .gnt_o (arb_gnt),
        .idx_o (win)
    );

    // The tag is pushed with the grant so a full FIFO blocks the next grant.
    assign fire   = (req != '0) && (bcnt_q < BW'(MAX_BURST))
                    && (cnt_q != CW'(FD));
    assign gnt    = fire ? arb_gnt : '0;
    assign pop    = app_mem_ack && (cnt_q != '0);
    assign orphan = app_mem_ack && (cnt_q == '0);

    always_comb begin
        ptr_d   = fire ? TW'(rr_next(int'(win), NREQ)) : ptr_q;
        bcnt_d  = fire ? bcnt_q + 1'b1 : '0;
        rd_d    = fire;
        raddr_d = raddr_q;
        if (fire) begin
            raddr_d = req_addr[int'(win)*DEPTH_NBITS +: DEPTH_NBITS];
        end
        vld_d = '0;
        if (pop) begin
            vld_d[fifo_q[rp_q]] = 1'b1;
        end
        data_d = pop ? app_mem_rdata : data_q;
        err_d  = err_q | orphan;
        wp_d   = wp_q;
        if (fire) begin
            wp_d = (wp_q == PW'(FD - 1)) ? '0 : wp_q + 1'b1;
        end
        rp_d = rp_q;
        if (pop) begin
            rp_d = (rp_q == PW'(FD - 1)) ? '0 : rp_q + 1'b1;
        end
        unique case ({fire, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q   <= '0;
            bcnt_q  <= '0;
            rd_q    <= 1'b0;
            raddr_q <= '0;
            vld_q   <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
            wp_q    <= '0;
            rp_q    <= '0;
            cnt_q   <= '0;
            for (int i = 0; i < FD; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            ptr_q   <= ptr_d;
            bcnt_q  <= bcnt_d;
            rd_q    <= rd_d;
            raddr_q <= raddr_d;
            vld_q   <= vld_d;
            data_q  <= data_d;
            err_q   <= err_d;
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            cnt_q   <= cnt_d;
            if (fire) begin
                fifo_q[wp_q] <= win;
            end
        end
    end

    assign rsp_vld        = vld_q;
    assign rsp_data       = data_q;
    assign app_mem_rd     = rd_q;
    assign app_mem_raddr  = raddr_q;
    assign err_orphan_ack = err_q;

endmodule

// File: tb/tb_pio_mem_rd_arb.sv
// Directed bench for pio_mem_rd_arb with a fixed-latency memory model
// that can withhold acks and track a pending PIO read.
module tb_pio_mem_rd_arb;

    localparam int MEM_LAT = 3;

    typedef struct {
        int          cyc;
        logic [3:0]  v;
        logic [19:0] d;
    } ev_t;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [39:0] req_addr;
    logic [3:0]  gnt;
    logic [3:0]  rsp_vld;
    logic [19:0] rsp_data;
    logic        app_mem_rd;
    logic [9:0]  app_mem_raddr;
    logic        app_mem_ack;
    logic [19:0] app_mem_rdata;
    logic        err_orphan_ack;

    logic       model_ack;
    logic       force_ack;
    logic       stall;
    logic       pio_pend;
    int         pio_done;
    int         cyc;
    int         checks;
    int         errors;
    int         left [4];
    logic [9:0] a [4];
    ev_t        gq [$];
    ev_t        rq [$];
    ev_t        aq [$];
    ev_t        mq [$];

    assign req_addr    = {a[3], a[2], a[1], a[0]};
    assign app_mem_ack = model_ack | force_ack;

    pio_mem_rd_arb dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req            (req),
        .req_addr       (req_addr),
        .gnt            (gnt),
        .rsp_vld        (rsp_vld),
        .rsp_data       (rsp_data),
        .app_mem_rd     (app_mem_rd),
        .app_mem_raddr  (app_mem_raddr),
        .app_mem_ack    (app_mem_ack),
        .app_mem_rdata  (app_mem_rdata),
        .err_orphan_ack (err_orphan_ack)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1);
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [19:0] rdata(input logic [9:0] ad);
        return (ad == 10'h005) ? 20'h0ABCD : {10'h2A5, ad};
    endfunction

    // Memory model: ack MEM_LAT cycles after the rd strobe, in order.
    always @(negedge clk) begin
        if (gnt != '0) gq.push_back('{cyc, gnt, 20'h0});
        if (rsp_vld != '0) rq.push_back('{cyc, rsp_vld, rsp_data});
        if (app_mem_rd) begin
            aq.push_back('{cyc, 4'h0, {10'h0, app_mem_raddr}});
            mq.push_back('{cyc + MEM_LAT, 4'h0, {10'h0, app_mem_raddr}});
        end
        if (pio_pend && !app_mem_rd) begin
            pio_pend = 1'b0;
            pio_done = cyc;
        end
        model_ack = 1'b0;
        if (!stall && mq.size() > 0 && mq[0].cyc <= cyc) begin
            model_ack     = 1'b1;
            app_mem_rdata = rdata(mq[0].d[9:0]);
            void'(mq.pop_front());
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic bit any_left();
        return (left[0] + left[1] + left[2] + left[3]) > 0;
    endfunction

    task automatic run(input int budget);
        for (int k = 0; k < budget; k++) begin
            if (!any_left()) break;
            @(posedge clk); #1;
            for (int i = 0; i < 4; i++) req[i] = left[i] > 0;
            #1;
            for (int i = 0; i < 4; i++) if (gnt[i]) left[i]--;
        end
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) req[i] = left[i] > 0;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clr();
        gq.delete();
        rq.delete();
        aq.delete();
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        wait_cyc(2);
        rst_n = 1'b1;
        clr();
    endtask

    int c0;

    initial begin
        checks = 0; errors = 0; cyc = 0;
        rst_n = 1'b1; req = '0; force_ack = 1'b0; stall = 1'b0;
        model_ack = 1'b0; app_mem_rdata = '0; pio_pend = 1'b0;
        pio_done = 0;
        for (int i = 0; i < 4; i++) begin
            left[i] = 0;
            a[i] = '0;
        end
        #2 rst_n = 1'b0;
        #1;
        check("rst_gnt", gnt, 4'h0);
        check("rst_rsp_vld", rsp_vld, 4'h0);
        check("rst_rsp_data", rsp_data, 20'h0);
        check("rst_rd", app_mem_rd, 1'b0);
        check("rst_raddr", app_mem_raddr, 10'h0);
        check("rst_err", err_orphan_ack, 1'b0);
        wait_cyc(2);
        rst_n = 1'b1;
        clr();

        // Single read from requester 1.
        a[1] = 10'h005; left[1] = 1;
        run(10);
        wait_cyc(8);
        c0 = gq[0].cyc;
        check("t1_ngnt", gq.size(), 1);
        check("t1_gnt", gq[0].v, 4'b0010);
        check("t1_rd_cyc", aq[0].cyc - c0, 1);
        check("t1_raddr", aq[0].d, 20'h005);
        check("t1_nrsp", rq.size(), 1);
        check("t1_rsp_cyc", rq[0].cyc - c0, 5);
        check("t1_rsp_vld", rq[0].v, 4'b0010);
        check("t1_rsp_data", rq[0].d, 20'h0ABCD);

        // All four requesting together.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            a[i] = 10'h010 + 10'(i);
            left[i] = 1;
        end
        run(10);
        wait_cyc(10);
        c0 = gq[0].cyc;
        check("t2_ngnt", gq.size(), 4);
        check("t2_nrd", aq.size(), 4);
        check("t2_nrsp", rq.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check("t2_gnt", gq[i].v, 4'b0001 << i);
            check("t2_gnt_cyc", gq[i].cyc - c0, i);
            check("t2_raddr", aq[i].d, 20'h010 + 20'(i));
            check("t2_rsp_cyc", rq[i].cyc - c0, i + 5);
            check("t2_rsp_vld", rq[i].v, 4'b0001 << i);
            check("t2_rsp_data", rq[i].d, rdata(10'h010 + 10'(i)));
        end

        // Long burst from requester 2 with a PIO read injected.
        do_reset();
        a[2] = 10'h0C3; left[2] = 18;
        fork
            run(40);
            begin
                repeat (3) @(posedge clk);
                pio_pend = 1'b1;
            end
        join
        wait_cyc(10);
        c0 = gq[0].cyc;
        check("t3_ngnt", gq.size(), 18);
        check("t3_nrsp", rq.size(), 18);
        for (int g = 0; g < 18; g++) begin
            check("t3_gnt_cyc", gq[g].cyc - c0, g + g / 8);
            check("t3_rsp_cyc", rq[g].cyc - c0, g + g / 8 + 5);
        end
        check("t3_rsp_vld", rq[17].v, 4'b0100);
        check("t3_rsp_data", rq[17].d, rdata(10'h0C3));
        check("t3_pio_pend", pio_pend, 1'b0);
        check("t3_pio_cyc", pio_done - c0, 9);

        // Memory withholds acks.
        do_reset();
        stall = 1'b1;
        a[0] = 10'h2F0; left[0] = 8;
        run(12);
        check("t4_stall_ngnt", gq.size(), 5);
        check("t4_stall_nrsp", rq.size(), 0);
        stall = 1'b0;
        run(40);
        wait_cyc(12);
        check("t4_ngnt", gq.size(), 8);
        check("t4_nrsp", rq.size(), 8);
        for (int i = 0; i < 8; i++) begin
            check("t4_rsp_vld", rq[i].v, 4'b0001);
            check("t4_rsp_data", rq[i].d, rdata(10'h2F0));
        end
        check("t4_err", err_orphan_ack, 1'b0);

        // Orphan ack with nothing in flight.
        do_reset();
        @(posedge clk); #1;
        force_ack = 1'b1;
        @(posedge clk); #1;
        force_ack = 1'b0;
        wait_cyc(2);
        check("t5_err", err_orphan_ack, 1'b1);
        wait_cyc(5);
        check("t5_err_sticky", err_orphan_ack, 1'b1);
        check("t5_nrsp", rq.size(), 0);

        // Reset with three reads in flight.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            a[i] = 10'h100 + 10'(i);
            left[i] = 1;
        end
        run(10);
        #5;
        check("t6_pre_rd", app_mem_rd, 1'b1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_gnt", gnt, 4'h0);
        check("t6_rst_rd", app_mem_rd, 1'b0);
        check("t6_rst_raddr", app_mem_raddr, 10'h0);
        check("t6_rst_vld", rsp_vld, 4'h0);
        check("t6_rst_data", rsp_data, 20'h0);
        wait_cyc(1);
        rst_n = 1'b1;
        clr();
        wait_cyc(6);
        check("t6_late_err", err_orphan_ack, 1'b1);
        check("t6_late_nrsp", rq.size(), 0);
        a[3] = 10'h3FF; left[3] = 1;
        run(10);
        wait_cyc(8);
        c0 = gq[0].cyc;
        check("t6_new_gnt", gq[0].v, 4'b1000);
        check("t6_new_nrsp", rq.size(), 1);
        check("t6_new_rsp_cyc", rq[0].cyc - c0, 5);
        check("t6_new_rsp_vld", rq[0].v, 4'b1000);
        check("t6_new_rsp_data", rq[0].d, rdata(10'h3FF));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pio_mem_rd_arb.md
Name: pio_mem_rd_arb

Overview:
- Shares the application read port of one PIO-accessible memory (pio_mem_ultra class) between NREQ requesters.
- Round-robin grant; one read issued per cycle; read data is routed back to the issuing requester through an in-flight tag FIFO.
- A burst limiter inserts idle cycles so PIO register reads, which app reads pre-empt inside the memory, cannot be starved.
- Sits between datapath lookup engines and the memory's app_mem_rd/app_mem_raddr/app_mem_ack/app_mem_rdata port.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 20, memory data width.
- DEPTH_NBITS, 10, memory address width.
- MEM_LAT, 3, cycles from app_mem_rd to app_mem_ack (fixed by the memory).
- MAX_BURST, 8, maximum consecutive issue cycles before a forced idle cycle.

Ports:
- clk  in  1  core clock.
- `RESET_SIG  in  1  asynchronous, active-low reset.
- req  in  NREQ  per-requester read request; held until gnt.
- req_addr  in  NREQ*DEPTH_NBITS  per-requester address; requester i uses slice i.
- gnt  out  NREQ  one-hot grant, combinational; request accepted this cycle.
- rsp_vld  out  NREQ  one-hot response valid, registered.
- rsp_data  out  WIDTH  response data, registered; valid only with rsp_vld.
- app_mem_rd  out  1  memory read strobe, registered.
- app_mem_raddr  out  DEPTH_NBITS  memory read address, registered.
- app_mem_ack  in  1  memory read ack.
- app_mem_rdata  in  WIDTH  memory read data, valid with app_mem_ack.
- err_orphan_ack  out  1  sticky: ack received with no read in flight.

Behaviour:
- Reset values: gnt=0, rsp_vld=0, rsp_data=0, app_mem_rd=0, app_mem_raddr=0, err_orphan_ack=0.
- Internal reset state: rr pointer=0, burst count=0, tag FIFO empty.

Grant rules, cycle T:
- A grant is issued iff req!=0, the burst count is below MAX_BURST, and the tag FIFO is not full.
- The winner is the first set req bit at or after the rr pointer, wrapping modulo NREQ.
- On a grant, the rr pointer moves to winner+1 (wrapping NREQ-1 -> 0).
- A requester may present a new request in the cycle after its grant. Back-to-back grants to the same requester are allowed when it is the only requester.

Issue:
- At T+1: app_mem_rd=1 and app_mem_raddr=req_addr[winner], captured at T.
- The winner index is pushed to the tag FIFO at T+1.

Response:
- app_mem_ack arrives at T+1+MEM_LAT.
- On the following cycle: rsp_vld[head tag]=1 and rsp_data=app_mem_rdata; the FIFO head is popped.
- Total latency from grant to rsp_vld is MEM_LAT+2, i.e. 5 at default.
- Responses return in issue order.

Tag FIFO:
- Depth is MEM_LAT+2, which covers full-rate issue.
- Push and pop in the same cycle are legal; count is unchanged.
- Full occurs only if acks stall, which is a protocol violation by the memory. Grants are blocked while full.

Burst limiter:
- Burst count increments on each issue cycle and clears on any non-issue cycle.
- When the count reaches MAX_BURST, gnt is forced to 0 for exactly one cycle, then the count clears.
- The forced idle cycle gives the memory one cycle with app_mem_rd_d1=0, so a pending PIO read completes.

Orphan ack:
- app_mem_ack with an empty FIFO sets err_orphan_ack, which stays set until reset.
- No rsp_vld is produced and FIFO state is unchanged.

Reset mid-operation:
- All in-flight reads are discarded.
- Acks arriving after reset release with an empty FIFO set err_orphan_ack. This is intended and tells software that a reset was not quiesced.

Decomposition:
- Shared package holds:
  - the MEM_LAT default constant;
  - a function to compute tag width, clog2(NREQ);
  - an rr_next helper.
- Sub-module rr_arb (NREQ): req, pointer -> one-hot gnt and winner index. It is combinational and reusable by other PIO arbiters.
- The tag FIFO stays inline: a small register array with a count.

Test Plan:
- Single requester 1 reads addr 0x005, memory returns 0x0ABCD -> gnt[1] at T, app_mem_rd at T+1, rsp_vld=4'b0010 with rsp_data=0x0ABCD at T+5.
- All four requesters held high for 4 cycles at addresses 0x10..0x13 -> grants 0,1,2,3 in order, four consecutive app_mem_rd, responses 4'b0001..4'b1000 in order with matching data.
- Requester 2 alone held for 20 cycles -> 8 grants, 1 idle cycle, 8 grants, 1 idle, 2 grants. PIO read injected during the burst gets mem_ack within 2 cycles of the idle slot.
- Ack stalled (memory model withholds acks) -> exactly MEM_LAT+2=5 grants, then gnt=0 until acks resume; no lost or duplicated responses.
- app_mem_ack pulsed with nothing in flight -> err_orphan_ack=1 and stays 1; rsp_vld stays 0.
- Reset asserted with 3 reads in flight -> all outputs 0 immediately (async). After release, the first new read completes normally; late acks set err_orphan_ack.
